// File: rtl/step_tick_gen_if.sv
// Control/status bundle between the step tick generator and its controller.
// Optional overrun signals exist only when STEP_TICK_OVERRUN_EN is defined.
interface step_tick_gen_if #(
    parameter int SPEED_W = 3,
    parameter int GEN_W   = 16
);
    logic               run;
    logic               step_req;
    logic [SPEED_W-1:0] speed;
    logic               busy;
    logic               pix_ce;
    logic               step_ce;
    logic               paused;
    logic [GEN_W-1:0]   gen_cnt;
`ifdef STEP_TICK_OVERRUN_EN
    logic               overrun;
    logic               overrun_clr;

    modport master (
        output run, step_req, speed, busy, overrun_clr,
        input  pix_ce, step_ce, paused, gen_cnt, overrun
    );

    modport slave (
        input  run, step_req, speed, busy, overrun_clr,
        output pix_ce, step_ce, paused, gen_cnt, overrun
    );
`else
    modport master (
        output run, step_req, speed, busy,
        input  pix_ce, step_ce, paused, gen_cnt
    );

    modport slave (
        input  run, step_req, speed, busy,
        output pix_ce, step_ce, paused, gen_cnt
    );
`endif
endinterface

// File: rtl/step_tick_gen.sv
// Step tick generator: derives the pixel-rate enable and a paced
// generation-step enable from clk, with run / pause / single-step control
// and a busy handshake toward the automaton core.
// Optional macro STEP_TICK_OVERRUN_EN adds a sticky overrun flag for
// requests dropped while one is already pending.
//
// state | meaning
// PAUSE | paused=1, step counter held, step_req accepted
// RUN   | step counter running, each terminal count raises a step request
module step_tick_gen #(
    parameter int PIX_DIV  = 2,
    parameter int BASE_DIV = 1562500,
    parameter int SPEED_W  = 3,
    parameter int GEN_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    step_tick_gen_if.slave bus
);
    localparam int PIX_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
    // Wide enough for BASE_DIV shifted by the largest speed value.
    localparam int CNT_W = $clog2(BASE_DIV + 1) + (1 << SPEED_W) - 1;

    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] BASE_EXT  = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(BASE_DIV - 1);

    localparam logic [0:0] ST_PAUSE = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [PIX_W-1:0] pix_div;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] reload_val;
    logic [0:0]       state;
    logic [0:0]       state_next;
    logic             pending;
    logic             tick;
    logic             step_accept;
    logic             req;
    logic             issue;
    logic             dropped;

    // Request, issue and drop decisions for the current cycle.
    always_comb begin
        reload_val  = (BASE_EXT << bus.speed) - CNT_W'(1);
        tick        = (state == ST_RUN) && (step_cnt == '0);
        step_accept = (state == ST_PAUSE) && !bus.run && bus.step_req;
        req         = tick || step_accept;
        issue       = pending && !bus.busy;
        dropped     = req && pending;
        state_next  = state;
        if (state == ST_PAUSE) begin
            if (bus.run) state_next = ST_RUN;
        end else begin
            if (!bus.run) state_next = ST_PAUSE;
        end
    end

    // Free-running pixel divider; pix_ce follows the terminal count by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_div    <= '0;
            bus.pix_ce <= 1'b0;
        end else if (pix_div == PIX_LAST) begin
            pix_div    <= '0;
            bus.pix_ce <= 1'b1;
        end else begin
            pix_div    <= pix_div + PIX_W'(1);
            bus.pix_ce <= 1'b0;
        end
    end

    // Run/pause state with a registered paused flag that tracks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_PAUSE;
            bus.paused <= 1'b1;
        end else begin
            state      <= state_next;
            bus.paused <= (state_next == ST_PAUSE);
        end
    end

    // Step period down-counter; reloads on RUN entry and at terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= CNT_RESET;
        end else if (state == ST_PAUSE) begin
            if (bus.run) step_cnt <= reload_val;
        end else if (step_cnt == '0) begin
            step_cnt <= reload_val;
        end else begin
            step_cnt <= step_cnt - CNT_W'(1);
        end
    end

    // One-deep pending request; a new request while full is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (pending) begin
            pending <= !issue;
        end else begin
            pending <= req;
        end
    end

    // Step enable and generation count, issued once the core is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.step_ce <= 1'b0;
            bus.gen_cnt <= '0;
        end else begin
            bus.step_ce <= issue;
            if (issue) bus.gen_cnt <= bus.gen_cnt + GEN_W'(1);
        end
    end

`ifdef STEP_TICK_OVERRUN_EN
    // Sticky overrun flag; a drop in the same cycle as clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overrun <= 1'b0;
        end else if (dropped) begin
            bus.overrun <= 1'b1;
        end else if (bus.overrun_clr) begin
            bus.overrun <= 1'b0;
        end
    end
`else
    logic unused_dropped;
    assign unused_dropped = dropped;
`endif
endmodule
